// File: rtl/bf16_entry_encoder_if.sv
// Keypad/result bundle for bf16_entry_encoder.
//   Keypad side (master drives): digit_valid, digit[3:0], key_point, key_neg,
//     key_enter, key_clear -- all one-cycle strobes.
//   Encoder side (slave drives): result[15:0] (BF16), result_valid (pulse),
//     busy, entry_overflow (sticky until clear).
interface bf16_entry_encoder_if;
  logic        digit_valid;
  logic [3:0]  digit;
  logic        key_point;
  logic        key_neg;
  logic        key_enter;
  logic        key_clear;
  logic [15:0] result;
  logic        result_valid;
  logic        busy;
  logic        entry_overflow;

  modport master (
    output digit_valid, digit, key_point, key_neg, key_enter, key_clear,
    input  result, result_valid, busy, entry_overflow
  );

  modport slave (
    input  digit_valid, digit, key_point, key_neg, key_enter, key_clear,
    output result, result_valid, busy, entry_overflow
  );
endinterface

// File: rtl/bf16_entry_encoder.sv
// Converts signed decimal keystrokes into one BF16 word.
// Integer and fraction digits are accumulated in binary; the fraction is
// turned into a 16-bit binary fraction by a restoring divider, the 33-bit
// fixed-point magnitude is normalised one bit per cycle and then rounded to
// nearest-even.
// Ports:
//   clk  - system clock
//   rst  - synchronous, active-high reset
//   kp   - slave side of bf16_entry_encoder_if (keys in, result/status out)
module bf16_entry_encoder #(
  parameter int INT_DIGITS  = 5,
  parameter int FRAC_DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  bf16_entry_encoder_if.slave  kp
);

  // 99999 needs 17 bits, 9999 needs 14 bits; the mag layout is fixed at 33 bits.
  localparam int          INT_W    = 17;
  localparam int          FRAC_W   = 14;
  localparam logic [2:0]  INT_MAX  = 3'(INT_DIGITS);
  localparam logic [2:0]  FRAC_MAX = 3'(FRAC_DIGITS);
  localparam logic [7:0]  EXP_INIT = 8'd143;   // bias 127 plus 16 fraction bits

  typedef enum logic [2:0] {
    ENT_INT, ENT_FRAC, DIVIDE, NORMALIZE, ROUND, DONE
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [INT_W-1:0]    r_int_acc;
  logic [FRAC_W-1:0]   r_frac_acc;
  logic [2:0]          r_int_cnt, r_frac_cnt;
  logic                r_neg, r_ovf;
  logic [14:0]         r_rem, r_div;
  logic [15:0]         r_frac_q;
  logic [3:0]          r_div_cnt;
  logic [32:0]         r_mag;
  logic [7:0]          r_exp;
  logic [15:0]         r_result;

  logic                w_entry, w_digit_ok;
  logic [15:0]         w_t, w_rem_nxt;
  logic                w_qbit;
  logic [15:0]         w_frac_q_nxt;
  logic [14:0]         w_round;

  // 10^n divisor ROM for n fraction digits.
  function automatic logic [14:0] pow10(input logic [2:0] n);
    case (n)
      3'd1:    return 15'd10;
      3'd2:    return 15'd100;
      3'd3:    return 15'd1000;
      3'd4:    return 15'd10000;
      default: return 15'd1;
    endcase
  endfunction

  // Round-to-nearest-even on a normalised magnitude (the implicit 1 is above
  // bit 31). A mantissa carry-out bumps the exponent.
  function automatic logic [14:0] round_rne(input logic [31:0] bits,
                                            input logic [7:0]  exp_in);
    logic [6:0] man;
    logic [7:0] e;
    logic       guard, sticky;
    man    = bits[31:25];
    guard  = bits[24];
    sticky = |bits[23:0];
    e      = exp_in;
    if (guard && (sticky || man[0])) begin
      if (man == 7'h7F) begin
        man = 7'h00;
        e   = e + 8'd1;
      end else begin
        man = man + 7'd1;
      end
    end
    return {e, man};
  endfunction

  assign w_entry      = (r_state == ENT_INT) || (r_state == ENT_FRAC);
  assign w_digit_ok   = kp.digit_valid && (kp.digit <= 4'd9);
  assign w_t          = {r_rem, 1'b0};
  assign w_qbit       = (w_t >= {1'b0, r_div});
  assign w_rem_nxt    = w_qbit ? (w_t - {1'b0, r_div}) : w_t;
  assign w_frac_q_nxt = {r_frac_q[14:0], w_qbit};
  assign w_round      = round_rne(r_mag[31:0], r_exp);

  assign kp.result         = r_result;
  assign kp.result_valid   = (r_state == DONE);
  assign kp.busy           = !w_entry;
  assign kp.entry_overflow = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ENT_INT;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ENT_INT, ENT_FRAC: begin
        if (kp.key_clear)
          w_state_nxt = ENT_INT;
        else if (kp.key_enter)
          w_state_nxt = (r_frac_cnt != 3'd0) ? DIVIDE : NORMALIZE;
        else if (kp.key_neg)
          w_state_nxt = r_state;
        else if (kp.key_point)
          w_state_nxt = ENT_FRAC;
      end
      DIVIDE:    if (r_div_cnt == 4'd15) w_state_nxt = NORMALIZE;
      NORMALIZE: begin
        if (r_mag == 33'd0)  w_state_nxt = DONE;
        else if (r_mag[32])  w_state_nxt = ROUND;
      end
      ROUND:     w_state_nxt = DONE;
      DONE:      w_state_nxt = ENT_INT;
      default:   w_state_nxt = ENT_INT;
    endcase
  end

  // The result register is written on the edge into DONE so that it is
  // already stable during the result_valid cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_int_acc  <= '0;
      r_frac_acc <= '0;
      r_int_cnt  <= '0;
      r_frac_cnt <= '0;
      r_neg      <= 1'b0;
      r_ovf      <= 1'b0;
      r_rem      <= '0;
      r_div      <= '0;
      r_frac_q   <= '0;
      r_div_cnt  <= '0;
      r_mag      <= '0;
      r_exp      <= '0;
      r_result   <= 16'h0000;
    end else begin
      case (r_state)
        ENT_INT, ENT_FRAC: begin
          if (kp.key_clear) begin
            r_int_acc  <= '0;
            r_frac_acc <= '0;
            r_int_cnt  <= '0;
            r_frac_cnt <= '0;
            r_neg      <= 1'b0;
            r_ovf      <= 1'b0;
          end else if (kp.key_enter) begin
            r_div_cnt <= '0;
            r_exp     <= EXP_INIT;
            if (r_frac_cnt != 3'd0) begin
              r_rem    <= {1'b0, r_frac_acc};
              r_div    <= pow10(r_frac_cnt);
              r_frac_q <= '0;
            end else begin
              // No fraction: skip the divider and load the magnitude directly.
              r_frac_q <= '0;
              r_mag    <= {r_int_acc, 16'h0000};
            end
          end else if (kp.key_neg) begin
            r_neg <= ~r_neg;
          end else if (kp.key_point) begin
            // handled by the state machine; consumes the cycle in either state
          end else if (w_digit_ok) begin
            if (r_state == ENT_INT) begin
              if (r_int_cnt < INT_MAX) begin
                r_int_acc <= r_int_acc * 17'd10 + {13'd0, kp.digit};
                r_int_cnt <= r_int_cnt + 3'd1;
              end else begin
                r_ovf <= 1'b1;
              end
            end else begin
              if (r_frac_cnt < FRAC_MAX) begin
                r_frac_acc <= r_frac_acc * 14'd10 + {10'd0, kp.digit};
                r_frac_cnt <= r_frac_cnt + 3'd1;
              end else begin
                r_ovf <= 1'b1;
              end
            end
          end
        end
        DIVIDE: begin
          r_rem     <= w_rem_nxt[14:0];
          r_frac_q  <= w_frac_q_nxt;
          r_div_cnt <= r_div_cnt + 4'd1;
          if (r_div_cnt == 4'd15)
            r_mag <= {r_int_acc, w_frac_q_nxt};
        end
        NORMALIZE: begin
          if (r_mag == 33'd0) begin
            r_result <= 16'h0000;           // zero is always emitted as +0
          end else if (!r_mag[32]) begin
            r_mag <= {r_mag[31:0], 1'b0};
            r_exp <= r_exp - 8'd1;
          end
        end
        ROUND: r_result <= {r_neg, w_round};
        DONE: begin
          r_int_acc  <= '0;
          r_frac_acc <= '0;
          r_int_cnt  <= '0;
          r_frac_cnt <= '0;
          r_neg      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bf16_entry_encoder.sv
module tb_bf16_entry_encoder;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bf16_entry_encoder_if kp_if ();

  bf16_entry_encoder #(.INT_DIGITS(5), .FRAC_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_keys();
    kp_if.digit_valid = 1'b0;
    kp_if.digit       = 4'd0;
    kp_if.key_point   = 1'b0;
    kp_if.key_neg     = 1'b0;
    kp_if.key_enter   = 1'b0;
    kp_if.key_clear   = 1'b0;
  endtask

  task automatic dig(input logic [3:0] d);
    kp_if.digit_valid = 1'b1;
    kp_if.digit       = d;
    tick();
    clr_keys();
  endtask

  task automatic pt();
    kp_if.key_point = 1'b1;
    tick();
    clr_keys();
  endtask

  task automatic ng();
    kp_if.key_neg = 1'b1;
    tick();
    clr_keys();
  endtask

  task automatic clr();
    kp_if.key_clear = 1'b1;
    tick();
    clr_keys();
  endtask

  // Press enter, wait for result_valid, check latency, value and busy window.
  // For the first 'noise' busy cycles every key strobe is held active.
  task automatic run_enter(input string tag, input logic [15:0] exp_res,
                           input int exp_lat, input int noise);
    int  c;
    bit  busy_err;
    kp_if.key_enter = 1'b1;
    tick();
    clr_keys();
    c = 1;
    busy_err = 1'b0;
    while (kp_if.result_valid !== 1'b1 && c < 200) begin
      if (kp_if.busy !== 1'b1) busy_err = 1'b1;
      if (c <= noise) begin
        kp_if.digit_valid = 1'b1;
        kp_if.digit       = 4'd9;
        kp_if.key_enter   = 1'b1;
        kp_if.key_neg     = 1'b1;
        kp_if.key_point   = 1'b1;
        kp_if.key_clear   = 1'b1;
      end else begin
        clr_keys();
      end
      tick();
      c++;
    end
    clr_keys();
    chk({tag, "_lat"}, 32'(c), 32'(exp_lat));
    chk({tag, "_res"}, 32'(kp_if.result), 32'(exp_res));
    chk({tag, "_busy_window"}, 32'({busy_err, kp_if.busy}), 32'b01);
    tick();
    chk({tag, "_after"}, 32'({kp_if.result_valid, kp_if.busy, kp_if.result}),
        32'({1'b0, 1'b0, exp_res}));
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    clr_keys();
    tick();
    tick();
    chk("reset_state",
        32'({kp_if.result, kp_if.result_valid, kp_if.busy, kp_if.entry_overflow}),
        32'({16'h0000, 1'b0, 1'b0, 1'b0}));
    rst = 1'b0;
    tick();

    // 12.5 with an out-of-range digit code in the middle
    dig(4'd1); dig(4'd12); dig(4'd2); pt(); dig(4'd5);
    run_enter("t1_12p5", 16'h4148, 32, 0);

    // -0.1
    ng(); dig(4'd0); pt(); dig(4'd1);
    run_enter("t2_m0p1", 16'hBDCD, 39, 0);

    // six 9s: last one dropped
    for (int i = 0; i < 6; i++) dig(4'd9);
    chk("t3_ovf_set", 32'(kp_if.entry_overflow), 32'd1);
    run_enter("t3_99999", 16'h47C3, 3, 0);
    chk("t3_ovf_kept", 32'(kp_if.entry_overflow), 32'd1);
    clr();
    chk("t3_ovf_clear", 32'(kp_if.entry_overflow), 32'd0);

    // 255.5: rounding carry into exponent
    dig(4'd2); dig(4'd5); dig(4'd5); pt(); dig(4'd5);
    run_enter("t4_255p5", 16'h4380, 28, 0);

    // zeros
    run_enter("t5_empty", 16'h0000, 2, 0);
    ng(); pt(); dig(4'd0);
    run_enter("t5_negzero", 16'h0000, 18, 0);

    // clear and digit together: digit discarded
    dig(4'd7);
    kp_if.key_clear   = 1'b1;
    kp_if.digit_valid = 1'b1;
    kp_if.digit       = 4'd3;
    tick();
    clr_keys();
    dig(4'd4);
    run_enter("t6_clr_dig", 16'h4080, 17, 0);

    // strobes during DIVIDE ignored
    dig(4'd3); pt(); dig(4'd2); dig(4'd5);
    run_enter("t6_noise", 16'h4050, 34, 6);
    dig(4'd1);
    run_enter("t6_post", 16'h3F80, 19, 0);

    // reset during DIVIDE cycle 5
    for (int i = 0; i < 6; i++) dig(4'd9);
    pt(); dig(4'd5);
    kp_if.key_enter = 1'b1;
    tick();
    clr_keys();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_outputs",
        32'({kp_if.result, kp_if.result_valid, kp_if.busy, kp_if.entry_overflow}),
        32'({16'h0000, 1'b0, 1'b0, 1'b0}));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (kp_if.result_valid !== 1'b0) seen = 1'b1;
      tick();
    end
    chk("t6_rst_no_valid", 32'(seen), 32'd0);
    dig(4'd1);
    run_enter("t6_rst_recover", 16'h3F80, 19, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bf16_entry_encoder.md
Name: bf16_entry_encoder

Overview:
- Keypad-side counterpart of the BF16-to-decimal display path. It turns a sequence of signed decimal keystrokes into a single BF16 word.
- Accumulates the integer and fraction digits, converts the fraction to binary with a serial divider, normalises, and rounds to nearest-even.
- Emits `result` with a one-cycle `result_valid` strobe. Output feeds the calculator datapath as an operand.

Parameters:
- INT_DIGITS, 5, maximum integer digits accepted (max 99999 fits 17 bits).
- FRAC_DIGITS, 4, maximum fraction digits accepted (divisor ≤ 10^4).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- digit_valid  in  1  one-cycle strobe, digit key pressed
- digit  in  4  digit value; values >9 ignored
- key_point  in  1  strobe, decimal point
- key_neg  in  1  strobe, toggle sign
- key_enter  in  1  strobe, start conversion
- key_clear  in  1  strobe, discard entry
- result  out  16  BF16 {sign, exp[7:0], man[6:0]}; held between conversions
- result_valid  out  1  one-cycle pulse when `result` updates
- busy  out  1  high from enter accepted until `result_valid` cycle inclusive
- entry_overflow  out  1  sticky; a digit was dropped at the digit-count limit

Behaviour:
- **Reset** (sync): state ENT_INT.
  - int_acc=0, frac_acc=0, int_cnt=0, frac_cnt=0, neg=0.
  - result=16'h0000, result_valid=0, busy=0, entry_overflow=0.
- **States:** ENT_INT, ENT_FRAC, DIVIDE, NORMALIZE, ROUND, DONE.
- **Entry states:** one action per cycle. Priority is clear > enter > neg > point > digit.
  - clear: zero accumulators, counts, neg and entry_overflow; go to ENT_INT.
  - neg: neg <= ~neg.
  - point: ENT_INT -> ENT_FRAC; ignored in ENT_FRAC.
  - digit in ENT_INT: if int_cnt<INT_DIGITS, int_acc <= int_acc*10+digit and int_cnt++; else drop the digit and set entry_overflow. Leading zeros count toward int_cnt.
  - digit in ENT_FRAC: same rule, applied to frac_acc/frac_cnt with FRAC_DIGITS.
- **Enter:** busy <= 1.
  - frac_cnt>0: rem <= frac_acc, D <= 10^frac_cnt (constant ROM), go to DIVIDE.
  - frac_cnt==0: frac_q=0, go to NORMALIZE.
- **While busy:** every key strobe is ignored.
- **DIVIDE:** exactly 16 cycles. Each cycle:
  - t = rem<<1.
  - qbit = (t >= D); rem <= qbit ? t-D : t.
  - frac_q <= {frac_q[14:0], qbit}.
  - Result is truncated; the final remainder is discarded.
- **NORMALIZE:**
  - First cycle loads mag[32:0] = {int_acc[16:0], frac_q[15:0]} and exp = 143 (127+16).
  - If mag==0: go to DONE with result 16'h0000. Sign is forced to 0, so -0 is never emitted.
  - Otherwise, while mag[32]==0: mag <<= 1 and exp-- each cycle. When mag[32]==1, go to ROUND.
- **ROUND** (1 cycle):
  - man = mag[31:25], guard = mag[24], sticky = |mag[23:0].
  - Increment when guard & (sticky | man[0]).
  - If man==7'h7F before the increment: man <= 0 and exp++.
- **DONE** (1 cycle):
  - result <= {neg, exp, man}; result_valid=1; busy deasserts at the next edge.
  - Clear accumulators, counts and neg; entry_overflow is retained until clear.
  - Next state ENT_INT.
- **Latency:** enter sampled at edge 0; result_valid is high in cycle L.
  - L = Dv + z + 3, where Dv = 16 if frac_cnt>0 else 0, and z = leading-zero count of the 33-bit mag.
  - Zero input: L = Dv + 2.
- **Exponent range:** stays within 127-16..143, so no overflow, underflow or denormal handling is needed.
- **Reset mid-conversion:** aborts with no result_valid; result returns to 0.

Test Plan:
1. "1","2",point,"5",enter -> result=16'h4148 (12.5), result_valid one cycle at L=16+13+3=32, busy high cycles 1..32.
2. neg,"0",point,"1",enter -> frac_q=16'h1999, round-up on sticky, result=16'hBDCD (-0.1).
3. Six "9" digits then enter -> 6th digit dropped, entry_overflow=1, result=16'h47C3 (99999 → 99840, guard 0). After key_clear, entry_overflow=0.
4. "2","5","5",point,"5",enter -> mantissa 7F with guard tie and lsb 1, carry into exponent, result=16'h4380 (256).
5. Zero cases:
   - enter with no digits -> result=16'h0000 at L=2.
   - neg, point, "0", enter -> result=16'h0000 (no -0) at L=18.
6. Hazards:
   - key_clear and digit_valid in the same cycle -> digit discarded.
   - Digit/enter strobes during DIVIDE -> ignored; result unchanged.
   - rst asserted at DIVIDE cycle 5 -> no result_valid, all outputs at reset values next cycle.
